// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator-side bridge between the core datapath and a word-organised data
// memory (asynchronous read, rising-edge synchronous write). Accepts RV32I
// byte/halfword/word loads and stores, performs sign/zero extension on loads
// and read-modify-write for sub-word stores. Misaligned, out-of-range and
// illegal-funct3 requests are answered with an error and never reach memory.
//
// Ports:
//   clk, reset        clock (rising edge) and synchronous active-high reset
//   req_valid/ready   request handshake; ready is high only while idle
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I width code (0 b, 1 h, 2 w, 4 bu, 5 hu)
//   req_addr          byte address
//   req_wdata         store data (low byte/half for sb/sh)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and errors), held until next accept
//   resp_err          request rejected, held until next accept
//   mem_addr          word index, 0 while idle
//   mem_write_data    word to write
//   mem_read_data     asynchronous read data from memory
//   mem_read          read strobe
//   mem_write         write strobe; memory commits on the edge while high
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic              mem_read,
    output logic              mem_write
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_STORE_RD = 3'd2;
    localparam logic [2:0] ST_STORE_WR = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    // Rejection rules evaluated on the raw request at acceptance.
    function automatic logic req_is_bad(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic range_bad;
        logic f3_bad;
        logic align_bad;
        range_bad = ((addr >> (MEM_AW + 2)) != 32'd0);
        // Stores allow only 0..2; loads reject 3, 6 and 7.
        f3_bad    = we ? (f3[2] | (f3[1:0] == 2'b11))
                       : ((f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7));
        align_bad = ((f3[1:0] == 2'b01) & addr[0]) |
                    ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        return range_bad | f3_bad | align_bad;
    endfunction

    // Lane selection plus sign/zero extension for a load result.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = word;
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the current memory word with store data.
    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word,
                                                input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: begin
                case (off)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wd;
                end else begin
                    r[15:0] = wd;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    logic [2:0]        state_r, state_s;
    logic              req_ready_r, req_ready_s;
    logic              resp_valid_r, resp_valid_s;
    logic [31:0]       resp_rdata_r, resp_rdata_s;
    logic              resp_err_r, resp_err_s;
    logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;   // doubles as the merge register
    logic              mem_read_r, mem_read_s;
    logic              mem_write_r, mem_write_s;
    logic [2:0]        funct3_r, funct3_s;
    logic [1:0]        off_r, off_s;
    logic [15:0]       wdata_r, wdata_s;

    // Next-state and next-output logic; every output is registered so strobes
    // are computed one state ahead and become visible in the owning state.
    always_comb begin
        state_s      = state_r;
        req_ready_s  = 1'b0;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata_r;
        resp_err_s   = resp_err_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        funct3_s     = funct3_r;
        off_s        = off_r;
        wdata_s      = wdata_r;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                mem_addr_s  = {MEM_AW{1'b0}};
                mem_wdata_s = 32'd0;
                if (req_valid) begin
                    req_ready_s  = 1'b0;
                    funct3_s     = req_funct3;
                    off_s        = req_addr[1:0];
                    wdata_s      = req_wdata[15:0];
                    mem_addr_s   = req_addr[MEM_AW+1:2];
                    resp_rdata_s = 32'd0;
                    resp_err_s   = 1'b0;
                    if (req_is_bad(req_we, req_funct3, req_addr)) begin
                        state_s      = ST_RESP;
                        resp_err_s   = 1'b1;
                        resp_valid_s = 1'b1;
                    end else if (!req_we) begin
                        state_s    = ST_LOAD;
                        mem_read_s = 1'b1;
                    end else if (req_funct3 == 3'd2) begin
                        // Full word store needs no read phase.
                        state_s     = ST_STORE_WR;
                        mem_write_s = 1'b1;
                        mem_wdata_s = req_wdata;
                    end else begin
                        state_s    = ST_STORE_RD;
                        mem_read_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                resp_rdata_s = load_extend(funct3_r, off_r, mem_read_data);
                resp_valid_s = 1'b1;
                state_s      = ST_RESP;
            end
            ST_STORE_RD: begin
                mem_wdata_s = store_merge(funct3_r, off_r, mem_read_data, wdata_r);
                mem_write_s = 1'b1;
                state_s     = ST_STORE_WR;
            end
            ST_STORE_WR: begin
                resp_valid_s = 1'b1;
                state_s      = ST_RESP;
            end
            ST_RESP: begin
                req_ready_s = 1'b1;
                mem_addr_s  = {MEM_AW{1'b0}};
                mem_wdata_s = 32'd0;
                state_s     = ST_IDLE;
            end
            default: begin
                req_ready_s = 1'b1;
                mem_addr_s  = {MEM_AW{1'b0}};
                mem_wdata_s = 32'd0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any
    // in-flight transaction so no write strobe follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            mem_addr_r   <= {MEM_AW{1'b0}};
            mem_wdata_r  <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            funct3_r     <= 3'd0;
            off_r        <= 2'd0;
            wdata_r      <= 16'd0;
        end else begin
            state_r      <= state_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            funct3_r     <= funct3_s;
            off_r        <= off_s;
            wdata_r      <= wdata_s;
        end
    end

    assign req_ready      = req_ready_r;
    assign resp_valid     = resp_valid_r;
    assign resp_rdata     = resp_rdata_r;
    assign resp_err       = resp_err_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_wdata_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: reset/abort sequence, a directed vector table, a
// back-to-back sequence and a randomized run checked against a byte-array
// reference model of the data memory.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic        do_init;
    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write)
    );

    function automatic logic [31:0] seed_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        return v * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Data memory: async read, X when not strobed, write on clk edge.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_write_data;
        end
    end
    assign mem_read_data = mem_read ? mem[mem_addr] : 32'hxxxxxxxx;

    // ---------------- reference model (byte-addressed memory) ----------------
    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        int   sz;
        if (addr >= 32'd1024) return 1'b1;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(addr) % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        n = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = 8'(wdata >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    function automatic int m_lat(input logic we, input logic [2:0] f3, input logic e);
        if (e) return 1;
        if (!we || f3 == 3'd2) return 2;
        return 3;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; returns just after the accepting edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_no_resp", 32'(resp_valid), 32'd0);
        check("rdata_hold", resp_rdata, last_rdata);
        check("err_hold", 32'(resp_err), 32'(last_err));
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
    endtask

    // Watch the busy cycles until resp_valid, with a cycle budget.
    task automatic wait_resp(input logic [7:0] idx, input logic keep_valid,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int nrd, output int nwr);
        lat = 0; nrd = 0; nwr = 0; rdata = 32'd0; err = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!keep_valid) req_valid = 1'b0;
            check("busy_not_ready", 32'(req_ready), 32'd0);
            check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (mem_read || mem_write) check("mem_addr", 32'(mem_addr), 32'(idx));
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk;
        logic [31:0] word;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input int nrd, input int nwr, input logic chk,
                                input logic [31:0] word);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.chk = chk; v.word = word;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        logic        er, e_err;
        int          lat, nrd, nwr;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, e_rd;
        logic [2:0]  legal_ld [5];

        legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2;
        legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;

        for (int w = 0; w < 256; w++) begin
            logic [31:0] v;
            v = seed_word(w);
            for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = v[8*b +: 8];
        end

        //                  we    f3    addr          wdata          rdata          err  lat rd wr chk word
        tbl[0]  = mk(1'b1, 3'd2, 32'h14,  32'h8899AABB, 32'h0,        1'b0, 2, 0, 1, 1'b1, 32'h8899AABB);
        tbl[1]  = mk(1'b0, 3'd2, 32'h14,  32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 3'd0, 32'h17,  32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 3'd4, 32'h17,  32'h0,        32'h00000088, 1'b0, 2, 1, 0, 1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 3'd1, 32'h14,  32'h0,        32'hFFFFAABB, 1'b0, 2, 1, 0, 1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 3'd5, 32'h16,  32'h0,        32'h00008899, 1'b0, 2, 1, 0, 1'b0, 32'h0);
        tbl[6]  = mk(1'b1, 3'd0, 32'h15,  32'h123456CC, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'h8899CCBB);
        tbl[7]  = mk(1'b1, 3'd1, 32'h16,  32'h00007777, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'h7777CCBB);
        tbl[8]  = mk(1'b0, 3'd2, 32'h16,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0);
        tbl[9]  = mk(1'b0, 3'd1, 32'h15,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0);
        tbl[10] = mk(1'b1, 3'd2, 32'h400, 32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, 3'd3, 32'h14,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0);
        tbl[12] = mk(1'b1, 3'd4, 32'h14,  32'h11111111, 32'h0,        1'b1, 1, 0, 0, 1'b1, 32'h7777CCBB);
        tbl[13] = mk(1'b0, 3'd2, 32'h14,  32'h0,        32'h7777CCBB, 1'b0, 2, 1, 0, 1'b0, 32'h0);

        reset = 1'b1; do_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        last_rdata = 32'd0; last_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_init = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;

        // Reset held 2 cycles while in STORE_RD abandons the sb to word 7.
        begin
            int wr_seen;
            wr_seen = 0;
            send(1'b1, 3'd0, 32'h1D, 32'h00000055);
            @(negedge clk);
            check("abort_in_store_rd", 32'(mem_read), 32'd1);
            req_valid = 1'b0;
            reset = 1'b1;
            wr_seen += int'(mem_write);
            repeat (2) begin
                @(negedge clk);
                wr_seen += int'(mem_write);
            end
            reset = 1'b0;
            check("abort_ready", 32'(req_ready), 32'd1);
            check("abort_resp_valid", 32'(resp_valid), 32'd0);
            repeat (3) begin
                @(negedge clk);
                wr_seen += int'(mem_write) + int'(resp_valid);
            end
            check("abort_no_write", 32'(wr_seen), 32'd0);
            check("abort_word", mem[7], ref_word(7));
        end

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
            wait_resp(tbl[i].addr[9:2], 1'b0, rd, er, lat, nrd, nwr);
            check("tbl_rdata", rd, tbl[i].rdata);
            check("tbl_err", 32'(er), 32'(tbl[i].err));
            check("tbl_latency", 32'(lat), 32'(tbl[i].lat));
            check("tbl_reads", 32'(nrd), 32'(tbl[i].nrd));
            check("tbl_writes", 32'(nwr), 32'(tbl[i].nwr));
            if (tbl[i].chk) check("tbl_word5", mem[5], tbl[i].word);
            if (tbl[i].we && !m_err(tbl[i].we, tbl[i].f3, tbl[i].addr))
                m_store(tbl[i].f3, tbl[i].addr, tbl[i].wdata);
            last_rdata = tbl[i].rdata;
            last_err   = tbl[i].err;
        end

        // Back-to-back: lw 0x14 then sb 0x10 with req_valid held high.
        send(1'b0, 3'd2, 32'h14, 32'd0);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'hA5A5A53C;
        wait_resp(8'd5, 1'b1, rd, er, lat, nrd, nwr);
        check("b2b_lw_rdata", rd, m_load(3'd2, 32'h14));
        check("b2b_lw_latency", 32'(lat), 32'd2);
        check("b2b_lw_reads", 32'(nrd), 32'd1);
        check("b2b_lw_writes", 32'(nwr), 32'd0);
        @(negedge clk);
        check("b2b_ready_after_resp", 32'(req_ready), 32'd1);
        check("b2b_pulse_end", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        wait_resp(8'd4, 1'b0, rd, er, lat, nrd, nwr);
        m_store(3'd0, 32'h10, 32'hA5A5A53C);
        check("b2b_sb_err", 32'(er), 32'd0);
        check("b2b_sb_rdata", rd, 32'd0);
        check("b2b_sb_latency", 32'(lat), 32'd3);
        check("b2b_sb_writes", 32'(nwr), 32'd1);
        check("b2b_sb_word", mem[4], ref_word(4));
        last_rdata = 32'd0;
        last_err   = 1'b0;

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else    f3 = legal_ld[$urandom_range(0, 4)];
            end
            if ($urandom_range(0, 15) == 0) addr = $urandom() | 32'h400;
            else addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
            wd = $urandom();
            e_err = m_err(we, f3, addr);
            e_rd  = (!e_err && !we) ? m_load(f3, addr) : 32'd0;
            send(we, f3, addr, wd);
            wait_resp(addr[9:2], 1'b0, rd, er, lat, nrd, nwr);
            check("rnd_rdata", rd, e_rd);
            check("rnd_err", 32'(er), 32'(e_err));
            check("rnd_latency", 32'(lat), 32'(m_lat(we, f3, e_err)));
            check("rnd_reads", 32'(nrd), (e_err || (we && f3 == 3'd2)) ? 32'd0 : 32'd1);
            check("rnd_writes", 32'(nwr), (!e_err && we) ? 32'd1 : 32'd0);
            if (we && !e_err) begin
                m_store(f3, addr, wd);
                check("rnd_word", mem[addr[9:2]], ref_word(int'(addr[9:2])));
            end
            last_rdata = e_rd;
            last_err   = e_err;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
